muldiv_hilo_unit: RTL and testbench

Parametrised iterative multiply/divide engine that owns the HI/LO register pair. It replaces the separate MUL/MULTU/DIV/DIVU/HILO blocks in the CPU datapath with one WIDTH-generic unit. It exposes a start/busy/done handshake, and the core uses `busy` to stall PC writes. It also supports MTHI/MTLO and a MUL variant that leaves HI/LO untouched.

---
 rtl/muldiv_hilo_unit.sv | 110 +++++++++++
 tb/tb_muldiv_hilo_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: iterative radix-2 multiply/divide engine owning HI/LO, with MTHI/MTLO and MUL.
// Define MULDIV_DBZ_FLAG_EN to add the dbz output flagging divide-by-zero alongside done.
module muldiv_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mul_lo
`ifdef MULDIV_DBZ_FLAG_EN
    ,
    output logic             dbz
`endif
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         op_q;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc, step, prod_fix;
    logic [WIDTH:0]     mul_sum, rem_sh, div_diff;
    logic [WIDTH-1:0]   q_fix, r_fix, abs_a, abs_b;
    logic               is_div, neg, sa, sb, b_zero;

    always_comb begin
        sa       = ~op[0] & rs_val[WIDTH-1];
        sb       = ~op[0] & rt_val[WIDTH-1];
        abs_a    = sa ? -rs_val : rs_val;
        abs_b    = sb ? -rt_val : rt_val;
        is_div   = op_q == 2'b01;
        neg      = sign_a ^ sign_b;
        b_zero   = mag_b == '0;
        // Multiply shifts the product right through the low half; divide shifts the dividend left into the remainder.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? mag_b : {WIDTH{1'b0}}};
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff = rem_sh - {1'b0, mag_b};
        step     = is_div ? {div_diff[WIDTH] ? rem_sh[WIDTH-1:0] : div_diff[WIDTH-1:0], acc[WIDTH-2:0], ~div_diff[WIDTH]}
                          : {mul_sum, acc[WIDTH-1:1]};
        prod_fix = neg ? -acc : acc;
        q_fix    = b_zero ? {WIDTH{1'b1}} : (neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        r_fix    = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        busy     = state == CALC || state == FIX;
        done     = state == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            mag_b  <= '0;
            acc    <= '0;
            hi     <= '0;
            lo     <= '0;
            mul_lo <= '0;
        end else begin
            case (state)
                IDLE: if (op_valid) begin
                    if (op == 3'b100) hi <= rs_val;
                    else if (op == 3'b101) lo <= rs_val;
                    else if (op != 3'b111) begin
                        state  <= CALC;
                        cnt    <= CNT_W'(WIDTH);
                        op_q   <= op[2:1];
                        sign_a <= sa;
                        sign_b <= sb;
                        mag_b  <= abs_b;
                        acc    <= {{WIDTH{1'b0}}, abs_a};
                    end
                end
                CALC: begin
                    acc <= step;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= FIX;
                end
                FIX: begin
                    state <= DONE;
                    if (op_q == 2'b00) {hi, lo} <= prod_fix;
                    else if (is_div) begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end else mul_lo <= prod_fix[WIDTH-1:0];
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MULDIV_DBZ_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst) dbz <= 1'b0;
        else dbz <= state == FIX && is_div && b_zero;
    end
`endif
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb_muldiv_hilo_unit: directed and random checks of muldiv_hilo_unit against a cycle-timed arithmetic model.
module tb_muldiv_hilo_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         op_valid = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] rs_val = '0, rt_val = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo, mul_lo;
`ifdef MULDIV_DBZ_FLAG_EN
    logic         dbz;
`endif

    muldiv_hilo_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .mul_lo(mul_lo)
`ifdef MULDIV_DBZ_FLAG_EN
        , .dbz(dbz)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int busy_seen = 0, done_seen = 0, dbz_seen = 0;
    bit started = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: results from plain arithmetic, timing from a busy countdown.
    int           m_left = 0;
    bit           m_done = 0, m_dbz = 0, p_dbz = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0, m_mul_lo = '0, p_hi, p_lo;
    logic [2:0]   p_op;

    task automatic compute(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p_dbz = 0;
        case (o)
            3'b000, 3'b110: p = 64'(sa * sb);
            3'b001: p = {32'b0, a} * {32'b0, b};
            3'b010: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {W'(sa % sb), W'(sa / sb)};
            default: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
        endcase
        if ((o == 3'b010 || o == 3'b011) && b == 0) p_dbz = 1;
        {p_hi, p_lo} = p;
        p_op = o;
    endtask

    always @(posedge clk) begin
        started = 1;
        if (rst) begin
            m_left = 0; m_done = 0; m_dbz = 0; m_hi = '0; m_lo = '0; m_mul_lo = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                if (p_op == 3'b110) m_mul_lo = p_lo;
                else begin m_hi = p_hi; m_lo = p_lo; end
                m_done = 1;
                m_dbz = p_dbz;
            end
        end else if (m_done) begin
            m_done = 0;
            m_dbz = 0;
        end else if (op_valid) begin
            case (op)
                3'b100: m_hi = rs_val;
                3'b101: m_lo = rs_val;
                3'b111: ;
                default: begin compute(op, rs_val, rt_val); m_left = W + 1; end
            endcase
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("busy", 64'(busy), 64'(m_left > 0));
            chk("done", 64'(done), 64'(m_done));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
            chk("mul_lo", 64'(mul_lo), 64'(m_mul_lo));
`ifdef MULDIV_DBZ_FLAG_EN
            chk("dbz", 64'(dbz), 64'(m_dbz));
            dbz_seen += int'(dbz);
`endif
            busy_seen += int'(busy);
            done_seen += int'(done);
        end
    end

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
        idle(1);
        op_valid = 1'b0; op = 3'($urandom); rs_val = $urandom; rt_val = $urandom;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0;
            3: return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    int b0, d0, z0;

    initial begin
        idle(3);
        rst = 1'b0;
        idle(1);
        b0 = busy_seen; d0 = done_seen;
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(34);
        chk("multu_busy_cycles", 64'(busy_seen - b0), 64'd33);
        chk("multu_done_pulses", 64'(done_seen - d0), 64'd1);
        chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(lo), 64'h0000_0001);
        issue(3'b000, 32'hFFFF_FFFD, 32'd5);
        idle(34);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFF1);
        issue(3'b110, 32'd6, 32'd7);
        idle(34);
        chk("mul_mul_lo", 64'(mul_lo), 64'd42);
        chk("mul_hi_kept", 64'(hi), 64'hFFFF_FFFF);
        chk("mul_lo_kept", 64'(lo), 64'hFFFF_FFF1);
        issue(3'b010, 32'hFFFF_FFF9, 32'd2);
        idle(34);
        chk("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
        issue(3'b011, 32'd7, 32'd2);
        idle(34);
        chk("divu_lo", 64'(lo), 64'd3);
        chk("divu_hi", 64'(hi), 64'd1);
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(34);
        chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
        chk("div_ovf_hi", 64'(hi), 64'h0);
        z0 = dbz_seen;
        issue(3'b011, 32'h1234, 32'h0);
        idle(34);
        chk("dbz_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("dbz_hi", 64'(hi), 64'h1234);
`ifdef MULDIV_DBZ_FLAG_EN
        chk("dbz_pulses", 64'(dbz_seen - z0), 64'd1);
`endif
        // Hold the request from the accept edge through the done cycle.
        d0 = done_seen;
        op_valid = 1'b1; op = 3'b011; rs_val = 32'd100; rt_val = 32'd7;
        idle(35);
        op_valid = 1'b0;
        idle(3);
        chk("held_done_pulses", 64'(done_seen - d0), 64'd1);
        chk("held_lo", 64'(lo), 64'd14);
        chk("held_hi", 64'(hi), 64'd2);
        issue(3'b011, 32'd50, 32'd5);
        idle(5);
        op_valid = 1'b1; op = 3'b100; rs_val = 32'hDEAD_BEEF;
        idle(10);
        op_valid = 1'b0;
        idle(25);
        chk("mthi_busy_hi", 64'(hi), 64'd0);
        chk("mthi_busy_lo", 64'(lo), 64'd10);
        issue(3'b101, 32'hA5A5_A5A5, 32'h0);
        chk("mtlo_lo", 64'(lo), 64'hA5A5_A5A5);
        chk("mtlo_busy", 64'(busy), 64'd0);
        chk("mtlo_done", 64'(done), 64'd0);
        issue(3'b010, 32'd1000, 32'd3);
        idle(9);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hilo", {32'(hi), 32'(lo)}, 64'd0);
        chk("abort_mul_lo", 64'(mul_lo), 64'd0);
        d0 = done_seen;
        idle(40);
        chk("abort_no_done", 64'(done_seen - d0), 64'd0);
        for (int i = 0; i < 60; i++) begin
            int hold;
            hold = $urandom_range(1, 40);
            op_valid = 1'b1; op = 3'($urandom_range(0, 7)); rs_val = pick(); rt_val = pick();
            idle(1);
            for (int k = 1; k < hold; k++) begin
                rs_val = pick(); rt_val = pick();
                idle(1);
            end
            op_valid = 1'b0;
            idle($urandom_range(0, 3));
        end
        idle(40);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
